// File: rtl/bt_uart_msg_rx_pkg.sv
// Shared constants and bit-FSM state encoding for the Bluetooth UART receive path.
package bt_uart_msg_rx_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 434;
    localparam int unsigned DEF_MAX_LEN      = 8;
    localparam int unsigned CNT_W            = 9;
    localparam int unsigned LEN_W            = 4;

    localparam logic [7:0] CHAR_HASH = 8'h23;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART deserialiser: 2-flop input synchroniser plus mid-bit sampling bit FSM.
module uart_rx_core
    import bt_uart_msg_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q;
    logic             rx_s_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shreg_q;

    // Synchroniser flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;
            cnt_q         <= cnt_q + CNT_W'(1);
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    // Re-check the line half a bit in; a short low pulse is ignored.
                    if (cnt_q == CNT_HALF) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s_q ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q              <= '0;
                        shreg_q[bit_idx_q] <= rx_s_q;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            rx_byte       <= shreg_q;
                            rx_byte_valid <= 1'b1;
                            state_q       <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state_q   <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    // Line held low: wait for it to return high before hunting a new start bit.
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/bt_uart_msg_rx.sv
// Bluetooth UART receiver: deserialises bytes and assembles terminator-delimited messages.
module bt_uart_msg_rx
    import bt_uart_msg_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned MAX_LEN      = DEF_MAX_LEN,
    parameter logic [7:0]  TERM_CHAR    = CHAR_HASH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [7:0]           rx_byte,
    output logic                 rx_byte_valid,
    output logic                 frame_err,
    output logic [8*MAX_LEN-1:0] msg_data,
    output logic [LEN_W-1:0]     msg_len,
    output logic                 msg_valid,
    output logic                 msg_overflow,
    output logic                 busy
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [8*MAX_LEN-1:0] buf_q;
    logic [LEN_W-1:0]     count_q;
    logic                 ovf_q;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    // Message assembler; buffer is cleared after every message so unused bytes read as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q        <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            msg_data     <= '0;
            msg_len      <= '0;
            msg_valid    <= 1'b0;
            msg_overflow <= 1'b0;
        end else begin
            msg_valid    <= 1'b0;
            msg_overflow <= 1'b0;
            if (frame_err) begin
                buf_q   <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else if (rx_byte_valid) begin
                if (rx_byte == TERM_CHAR) begin
                    if (ovf_q) begin
                        msg_overflow <= 1'b1;
                    end else begin
                        msg_data  <= buf_q;
                        msg_len   <= count_q;
                        msg_valid <= 1'b1;
                    end
                    buf_q   <= '0;
                    count_q <= '0;
                    ovf_q   <= 1'b0;
                end else if (count_q < LEN_MAX) begin
                    for (int unsigned i = 0; i < MAX_LEN; i++) begin
                        if (LEN_W'(i) == count_q) begin
                            buf_q[8*i +: 8] <= rx_byte;
                        end
                    end
                    count_q <= count_q + LEN_W'(1);
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

endmodule
